// File: rtl/battery_f_sprite_fetch.sv
// ---------------------------------------------------------------------------
// battery_f_sprite_fetch
//
// Per-pixel sprite fetch stage for the flashing-battery pickup. For every
// pixel of the VGA stream it decides whether the pixel lies inside the
// battery's SPR_W x SPR_H bounding box and addresses the external synchronous
// sprite ROM. It then returns a latency-aligned palette index and hit flag to
// the palette lookup stage. Sprite position, presence and low-charge state are
// latched once per frame. A low charge makes the sprite blink with a
// half-period of BLINK_FRAMES frames.
//
// Ports
//   Clk          pixel clock
//   Reset_n      synchronous active-low reset
//   vsync_start  one-cycle start-of-frame pulse; loads the frame registers
//   pos_x/pos_y  sprite top-left corner (sampled on vsync_start)
//   enable       battery present (sampled on vsync_start)
//   low_charge   blink request (sampled on vsync_start)
//   pix_valid    draw_x/draw_y carry a real pixel this cycle
//   draw_x/y     current pixel coordinates
//   rom_addr     sprite ROM address (row-major, dy*SPR_W + dx)
//   rom_rd       ROM read strobe, high only for in-box visible pixels
//   rom_data     ROM output, valid one cycle after rom_addr
//   out_valid    output pixel slot valid (two cycles after the input)
//   out_hit      opaque sprite pixel
//   out_index    palette index, 0 whenever the pixel is not a sprite pixel
// ---------------------------------------------------------------------------
module battery_f_sprite_fetch #(
    parameter int SPR_W           = 32,
    parameter int SPR_H           = 32,
    parameter int ADDR_W          = 10,
    parameter int TRANSPARENT_IDX = 2,
    parameter int BLINK_FRAMES    = 30
) (
    input  logic              Clk,
    input  logic              Reset_n,
    input  logic              vsync_start,
    input  logic [9:0]        pos_x,
    input  logic [9:0]        pos_y,
    input  logic              enable,
    input  logic              low_charge,
    input  logic              pix_valid,
    input  logic [9:0]        draw_x,
    input  logic [9:0]        draw_y,
    output logic [ADDR_W-1:0] rom_addr,
    output logic              rom_rd,
    input  logic [3:0]        rom_data,
    output logic              out_valid,
    output logic              out_hit,
    output logic [3:0]        out_index
);

    localparam int XB     = $clog2(SPR_W);
    localparam int FCNT_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    typedef enum logic {
        VISIBLE = 1'b0,
        HIDDEN  = 1'b1
    } blink_t;

    logic [9:0]        r_fx;
    logic [9:0]        r_fy;
    logic              r_fen;
    logic              r_flow;

    blink_t            r_state;
    blink_t            w_stateNext;
    logic [FCNT_W-1:0] r_fcnt;
    logic [FCNT_W-1:0] w_fcntNext;

    logic [10:0]       w_dx;
    logic [10:0]       w_dy;
    logic              w_inBox;
    logic              w_hit1;
    logic [ADDR_W-1:0] w_addr;

    logic [ADDR_W-1:0] r_romAddr;
    logic              r_romRd;
    logic              r_v1;
    logic              r_hit1;
    logic              r_v2;
    logic              r_hit2;
    logic              r_outValid;
    logic              r_outHit;
    logic [3:0]        r_outIndex;

    // Frame registers. They change only at the start of a frame, so the
    // pixel sampled alongside vsync_start still sees the previous frame's
    // position and flags.
    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            r_fx   <= '0;
            r_fy   <= '0;
            r_fen  <= 1'b0;
            r_flow <= 1'b0;
        end else if (vsync_start) begin
            r_fx   <= pos_x;
            r_fy   <= pos_y;
            r_fen  <= enable;
            r_flow <= low_charge;
        end
    end

    // Blink state register. It only moves on vsync_start, so visibility is
    // constant across a whole frame.
    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            r_state <= VISIBLE;
            r_fcnt  <= '0;
        end else begin
            r_state <= w_stateNext;
            r_fcnt  <= w_fcntNext;
        end
    end

    // Blink next-state logic. The incoming low_charge value decides the
    // behaviour, so the latching frame already counts as the first blink
    // frame. Dropping low_charge snaps straight back to VISIBLE.
    always_comb begin
        w_stateNext = r_state;
        w_fcntNext  = r_fcnt;
        if (vsync_start) begin
            if (!low_charge) begin
                w_stateNext = VISIBLE;
                w_fcntNext  = '0;
            end else if (r_fcnt == FCNT_W'(BLINK_FRAMES - 1)) begin
                w_fcntNext  = '0;
                w_stateNext = (r_state == VISIBLE) ? HIDDEN : VISIBLE;
            end else begin
                w_fcntNext  = r_fcnt + 1'b1;
            end
        end
    end

    // Box test. The differences are unsigned with one extra bit, so a pixel
    // left of or above the sprite wraps to a large value and fails the
    // range test. A sprite hanging off the 1023 edge is clipped rather than
    // aliased onto the opposite side of the screen.
    always_comb begin
        w_dx    = {1'b0, draw_x} - {1'b0, r_fx};
        w_dy    = {1'b0, draw_y} - {1'b0, r_fy};
        w_inBox = (w_dx < 11'(SPR_W)) && (w_dy < 11'(SPR_H));
        w_hit1  = pix_valid && r_fen && (r_state == VISIBLE) && w_inBox;
        w_addr  = {w_dy[ADDR_W-XB-1:0], w_dx[XB-1:0]};
    end

    // Stage 1: drive the ROM. Misses park the address at 0 and keep the
    // strobe low, so the ROM sees no activity for pixels outside the sprite.
    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            r_romAddr <= '0;
            r_romRd   <= 1'b0;
            r_v1      <= 1'b0;
            r_hit1    <= 1'b0;
        end else begin
            r_romAddr <= w_hit1 ? w_addr : '0;
            r_romRd   <= w_hit1;
            r_v1      <= pix_valid;
            r_hit1    <= w_hit1;
        end
    end

    // Stage 2: the ROM registers its address on this edge. Only the
    // qualifiers are delayed here to keep them aligned with rom_data.
    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            r_v2   <= 1'b0;
            r_hit2 <= 1'b0;
        end else begin
            r_v2   <= r_v1;
            r_hit2 <= r_hit1;
        end
    end

    // Stage 3: register the result. rom_data is masked with the delayed hit,
    // so leftover ROM output never leaks into bubbles or out-of-box pixels.
    // A transparent texel still reports its index but is not a hit.
    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            r_outValid <= 1'b0;
            r_outHit   <= 1'b0;
            r_outIndex <= '0;
        end else begin
            r_outValid <= r_v2;
            r_outHit   <= r_hit2 && (rom_data != 4'(TRANSPARENT_IDX));
            r_outIndex <= r_hit2 ? rom_data : 4'd0;
        end
    end

    assign rom_addr  = r_romAddr;
    assign rom_rd    = r_romRd;
    assign out_valid = r_outValid;
    assign out_hit   = r_outHit;
    assign out_index = r_outIndex;

endmodule

// File: tb/tb_battery_f_sprite_fetch.sv
// ---------------------------------------------------------------------------
// tb_battery_f_sprite_fetch
//
// Directed bench for the battery sprite fetch stage. A synchronous ROM model
// holds a fixed texel pattern. A frame-level model predicts every output slot
// from the pixel coordinates, and a negedge compare process checks the DUT
// against it on every cycle after reset. Hand-computed literal checks in the
// stimulus pin the model to known values.
// ---------------------------------------------------------------------------
module tb_battery_f_sprite_fetch;

    logic       Clk = 1'b0;
    logic       Reset_n;
    logic       vsync_start;
    logic [9:0] pos_x;
    logic [9:0] pos_y;
    logic       enable;
    logic       low_charge;
    logic       pix_valid;
    logic [9:0] draw_x;
    logic [9:0] draw_y;
    logic [9:0] rom_addr;
    logic       rom_rd;
    logic [3:0] rom_data;
    logic       out_valid;
    logic       out_hit;
    logic [3:0] out_index;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic       v;
        logic       hit;
        logic [9:0] addr;
        logic [3:0] idx;
        logic       ohit;
    } ent_t;

    ent_t       m1;
    ent_t       m2;
    ent_t       m3;
    ent_t       e;
    logic [9:0] mfx;
    logic [9:0] mfy;
    logic       mfen;
    int         lowCount;
    int         mdx;
    int         mdy;
    logic       mVisible;
    logic       mInBox;
    bit         modelLive = 0;

    battery_f_sprite_fetch dut (
        .Clk        (Clk),
        .Reset_n    (Reset_n),
        .vsync_start(vsync_start),
        .pos_x      (pos_x),
        .pos_y      (pos_y),
        .enable     (enable),
        .low_charge (low_charge),
        .pix_valid  (pix_valid),
        .draw_x     (draw_x),
        .draw_y     (draw_y),
        .rom_addr   (rom_addr),
        .rom_rd     (rom_rd),
        .rom_data   (rom_data),
        .out_valid  (out_valid),
        .out_hit    (out_hit),
        .out_index  (out_index)
    );

    always #5 Clk = ~Clk;

    // Texel pattern: address 0 holds 5, address 7 holds the transparent key 2.
    function automatic logic [3:0] romVal(input int a);
        romVal = 4'(a % 16) ^ 4'h5;
    endfunction

    // Synchronous sprite ROM with one cycle of read latency.
    always @(posedge Clk) begin
        rom_data <= romVal(int'(rom_addr));
    end

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            failures++;
            $display("[TB] FAIL %s at %0t: got %0d expected %0d", name, $time, actual, expected);
        end
    endtask

    // Frame-level model. Visibility comes from the number of consecutive
    // low-charge frames: blocks of 30 frames alternate visible and hidden,
    // and the latching frame counts as frame 1. The pipeline is three
    // entries deep, matching the two-cycle output latency.
    always @(posedge Clk) begin
        if (!Reset_n) begin
            m1        = '{default: 0};
            m2        = '{default: 0};
            m3        = '{default: 0};
            mfx       = 0;
            mfy       = 0;
            mfen      = 0;
            lowCount  = 0;
            modelLive = 1;
        end else begin
            mdx      = int'(draw_x) - int'(mfx);
            mdy      = int'(draw_y) - int'(mfy);
            mInBox   = (mdx >= 0) && (mdx < 32) && (mdy >= 0) && (mdy < 32);
            mVisible = (lowCount == 0) || (((lowCount / 30) % 2) == 0);
            e.v      = pix_valid;
            e.hit    = pix_valid && mfen && mVisible && mInBox;
            e.addr   = e.hit ? 10'(mdy * 32 + mdx) : 10'd0;
            e.idx    = e.hit ? romVal(mdy * 32 + mdx) : 4'd0;
            e.ohit   = e.hit && (e.idx != 4'd2);
            m3 = m2;
            m2 = m1;
            m1 = e;
            if (vsync_start) begin
                mfx      = pos_x;
                mfy      = pos_y;
                mfen     = enable;
                lowCount = low_charge ? lowCount + 1 : 0;
            end
        end
    end

    // Compare process, on the falling edge away from DUT updates.
    always @(negedge Clk) begin
        if (modelLive) begin
            checkOutput("rom_addr",  int'(rom_addr),  int'(m1.addr));
            checkOutput("rom_rd",    int'(rom_rd),    int'(m1.hit));
            checkOutput("out_valid", int'(out_valid), int'(m3.v));
            checkOutput("out_hit",   int'(out_hit),   int'(m3.ohit));
            checkOutput("out_index", int'(out_index), int'(m3.idx));
        end
    end

    // Drive one cycle of inputs on the falling edge, then wait for the
    // rising edge that samples them.
    task automatic applyStimulus(input logic rst, input logic vs, input int px, input int py,
                                 input logic en, input logic lc, input logic pv,
                                 input int x, input int y);
        @(negedge Clk);
        Reset_n     = rst;
        vsync_start = vs;
        pos_x       = 10'(px);
        pos_y       = 10'(py);
        enable      = en;
        low_charge  = lc;
        pix_valid   = pv;
        draw_x      = 10'(x);
        draw_y      = 10'(y);
        @(posedge Clk);
    endtask

    task automatic pixel(input int x, input int y);
        applyStimulus(1'b1, 1'b0, 0, 0, 1'b0, 1'b0, 1'b1, x, y);
    endtask

    task automatic bubble();
        applyStimulus(1'b1, 1'b0, 0, 0, 1'b0, 1'b0, 1'b0, 0, 0);
    endtask

    task automatic vsync(input int px, input int py, input logic en, input logic lc);
        applyStimulus(1'b1, 1'b1, px, py, en, lc, 1'b0, 0, 0);
    endtask

    initial begin
        Reset_n     = 1'b0;
        vsync_start = 1'b0;
        pos_x       = '0;
        pos_y       = '0;
        enable      = 1'b0;
        low_charge  = 1'b0;
        pix_valid   = 1'b0;
        draw_x      = '0;
        draw_y      = '0;

        applyStimulus(1'b0, 1'b0, 0, 0, 1'b0, 1'b0, 1'b0, 0, 0);
        applyStimulus(1'b0, 1'b0, 0, 0, 1'b0, 1'b0, 1'b0, 0, 0);
        #1;
        checkOutput("reset out_valid", int'(out_valid), 0);
        checkOutput("reset out_hit",   int'(out_hit),   0);
        checkOutput("reset out_index", int'(out_index), 0);
        checkOutput("reset rom_addr",  int'(rom_addr),  0);
        checkOutput("reset rom_rd",    int'(rom_rd),    0);

        vsync(100, 50, 1'b1, 1'b0);
        pixel(100, 50);
        #1 checkOutput("corner addr", int'(rom_addr), 0);
        checkOutput("corner rd", int'(rom_rd), 1);
        pixel(131, 81);
        #1 checkOutput("far corner addr", int'(rom_addr), 1023);
        pixel(99, 50);
        #1 checkOutput("left miss rd", int'(rom_rd), 0);
        checkOutput("corner out_valid", int'(out_valid), 1);
        checkOutput("corner out_hit",   int'(out_hit),   1);
        checkOutput("corner out_index", int'(out_index), 5);
        pixel(132, 50);
        #1 checkOutput("right miss rd", int'(rom_rd), 0);
        checkOutput("far corner index", int'(out_index), 10);
        pixel(100, 82);
        #1 checkOutput("below miss rd", int'(rom_rd), 0);
        checkOutput("left miss hit",   int'(out_hit),   0);
        checkOutput("left miss index", int'(out_index), 0);
        pixel(107, 50);
        #1 checkOutput("transparent addr", int'(rom_addr), 7);
        bubble();
        bubble();
        #1 checkOutput("transparent valid", int'(out_valid), 1);
        checkOutput("transparent hit",   int'(out_hit),   0);
        checkOutput("transparent index", int'(out_index), 2);
        bubble();
        #1 checkOutput("bubble valid", int'(out_valid), 0);

        vsync(1010, 1015, 1'b1, 1'b0);
        pixel(1020, 1020);
        #1 checkOutput("edge addr", int'(rom_addr), 170);
        pixel(5, 5);
        #1 checkOutput("no wrap rd", int'(rom_rd), 0);
        bubble();
        #1 checkOutput("edge hit", int'(out_hit), 1);
        checkOutput("edge index", int'(out_index), 15);
        bubble();
        #1 checkOutput("no wrap hit", int'(out_hit), 0);
        checkOutput("no wrap valid", int'(out_valid), 1);

        for (int c = 1; c <= 62; c++) begin
            vsync(100, 50, 1'b1, 1'b1);
            pixel(100, 50);
            bubble();
            bubble();
            #1;
            if (c == 29) checkOutput("blink frame 29 hit", int'(out_hit), 1);
            if (c == 30) checkOutput("blink frame 30 hit", int'(out_hit), 0);
            if (c == 59) checkOutput("blink frame 59 hit", int'(out_hit), 0);
            if (c == 60) checkOutput("blink frame 60 hit", int'(out_hit), 1);
        end
        for (int c = 1; c <= 31; c++) begin
            vsync(100, 50, 1'b1, 1'b1);
        end
        pixel(100, 50);
        #1 checkOutput("hidden rd", int'(rom_rd), 0);
        vsync(100, 50, 1'b1, 1'b0);
        pixel(100, 50);
        bubble();
        bubble();
        #1 checkOutput("blink cleared hit", int'(out_hit), 1);

        applyStimulus(1'b1, 1'b1, 200, 60, 1'b1, 1'b0, 1'b1, 100, 50);
        #1 checkOutput("vsync pixel old pos rd", int'(rom_rd), 1);
        checkOutput("vsync pixel old pos addr", int'(rom_addr), 0);
        pixel(100, 50);
        #1 checkOutput("new pos miss rd", int'(rom_rd), 0);
        pixel(200, 60);
        #1 checkOutput("new pos hit rd", int'(rom_rd), 1);
        pixel(231, 60);
        #1 checkOutput("new pos addr", int'(rom_addr), 31);

        pixel(200, 60);
        applyStimulus(1'b0, 1'b0, 0, 0, 1'b0, 1'b0, 1'b1, 200, 60);
        #1 checkOutput("mid reset valid", int'(out_valid), 0);
        checkOutput("mid reset rd", int'(rom_rd), 0);
        applyStimulus(1'b0, 1'b1, 300, 300, 1'b1, 1'b0, 1'b1, 300, 300);
        pixel(300, 300);
        #1 checkOutput("reset wins rd", int'(rom_rd), 0);
        checkOutput("post reset valid early", int'(out_valid), 0);
        bubble();
        #1 checkOutput("post reset valid", int'(out_valid), 0);
        bubble();
        #1 checkOutput("post reset first valid", int'(out_valid), 1);
        checkOutput("post reset first hit", int'(out_hit), 0);
        bubble();
        bubble();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/battery_f_sprite_fetch.md
# battery_f_sprite_fetch

Per-pixel sprite fetch stage for the flashing-battery pickup. Takes the VGA pixel stream, decides whether each pixel falls inside the battery's 32x32 bounding box, drives the address of the external synchronous battery sprite ROM, and produces a registered, latency-aligned 4-bit palette index plus hit flag. It sits directly upstream of the battery palette lookup, which converts `out_index` to 12-bit RGB. It also owns frame-synchronous position latching and the low-charge blink behaviour.

## Interface
- `SPR_W`, 32, sprite width in pixels (power of two)
- `SPR_H`, 32, sprite height in pixels
- `ADDR_W`, 10, sprite ROM address width (log2(SPR_W*SPR_H))
- `TRANSPARENT_IDX`, 2, palette index treated as transparent (magenta key)
- `BLINK_FRAMES`, 30, frames per blink half-period when low charge

- `Clk`  in  1  system/pixel clock
- `Reset_n`  in  1  synchronous, active-low reset
- `vsync_start`  in  1  one-cycle pulse at start of frame
- `pos_x`, `pos_y`  in  10 each  sprite top-left, sampled on `vsync_start`
- `enable`  in  1  battery present, sampled on `vsync_start`
- `low_charge`  in  1  blink request, sampled on `vsync_start`
- `pix_valid`  in  1  `draw_x`/`draw_y` valid this cycle
- `draw_x`, `draw_y`  in  10 each  current pixel coordinates
- `rom_addr`  out  ADDR_W  sprite ROM address
- `rom_rd`  out  1  ROM read strobe
- `rom_data`  in  4  ROM output, valid one cycle after `rom_addr`
- `out_valid`  out  1  output pixel slot valid
- `out_hit`  out  1  opaque sprite pixel
- `out_index`  out  4  palette index to palette stage

## Operation
- Frame registers `fx`, `fy`, `fen`, `flow` load from `pos_x`, `pos_y`, `enable`, `low_charge` only on cycles with `vsync_start`=1; the pixel sampled in the same cycle uses the old values.
- Blink FSM, states VISIBLE and HIDDEN, frame counter `fcnt` (width ceil(log2(BLINK_FRAMES))):
  - `flow`=0 (after load): state VISIBLE, `fcnt`=0.
  - `flow`=1: each `vsync_start` increments `fcnt`; when `fcnt`==BLINK_FRAMES-1, `fcnt`<=0 and state toggles.
  - Transition and load take effect together on the same `vsync_start`; state is constant for a whole frame.
- Stage 1 (registered on edge N when inputs are sampled):
  - `dx` = {1'b0,`draw_x`} - {1'b0,`fx`}, `dy` likewise, 11-bit unsigned; in-box iff `dx` < SPR_W and `dy` < SPR_H (wrap from negative differences is automatically out of range; sprites crossing x=1023/y=1023 clip).
  - `hit1` = `pix_valid` & `fen` & (state==VISIBLE) & in-box.
  - `rom_addr` <= `hit1` ? `dy`*SPR_W + `dx` (shift+or) : 0; `rom_rd` <= `hit1`; `v1` <= `pix_valid`.
- Stage 2 (edge N+1): ROM registers the address; `hit2`, `v2` delay `hit1`, `v1`.
- Stage 3 (edge N+2): `out_valid` <= `v2`; `out_hit` <= `hit2` & (`rom_data` != TRANSPARENT_IDX); `out_index` <= `hit2` ? `rom_data` : 0.
- Out-of-box or invalid pixels never expose stale ROM data: `out_index` = 0, `out_hit` = 0.

## Timing
- Latency: pixel sampled at edge N appears on outputs after edge N+2; fully pipelined, one pixel per cycle, no stalls, no back-pressure.
- `rom_addr`/`rom_rd` valid after edge N; `rom_data` required valid after edge N+1.
- Reset (`Reset_n`=0 at an edge): all outputs 0, `rom_addr`=0, pipeline valids cleared, `fx`=`fy`=0, `fen`=0, `flow`=0, state VISIBLE, `fcnt`=0. Mid-frame reset discards in-flight pixels; first valid output is 2 cycles after the first post-reset `pix_valid`.
- `vsync_start` with `Reset_n`=0: reset wins, nothing loads.
- Bubbles (`pix_valid`=0) propagate as `out_valid`=0 with `out_hit`=0, `out_index`=0.

## Test plan
- Reset then `vsync_start` with pos (100,50), enable=1; pixel (100,50) -> `rom_addr`=0 after 1 cycle; ROM returns 5 -> `out_valid`=1, `out_hit`=1, `out_index`=5 exactly 2 cycles after input.
- Same frame, pixel (131,81) -> `rom_addr`=1023; pixels (99,50), (132,50), (100,82) -> `rom_rd`=0, `out_hit`=0, `out_index`=0.
- ROM returns 2 (transparent) for in-box pixel -> `out_hit`=0, `out_index`=2, `out_valid`=1.
- pos (1010,1015): pixel (1020,1020) -> hit, `rom_addr`=5*32+10=170; pixel (5,5) -> no hit (no wrap-around aliasing).
- `low_charge`=1 latched, BLINK_FRAMES=30: frames 1-29 after latch hit normally, frame 30 onward (for 30 frames) no hits; clearing `low_charge` restores VISIBLE at next `vsync_start`.
- `vsync_start` same cycle as pixel with new pos: that pixel uses old pos, next pixel uses new; assert `Reset_n`=0 mid-stream -> `out_valid`=0 following edge.
